// File: rtl/uart_alu_if.sv
// Command engine between the UART FIFOs: pops three-byte frames (A, B, opcode),
// evaluates an 8-bit ALU operation and pushes the one-byte result back out.
module uart_alu_if #(
   parameter int TIMEOUT_CYC = 50_000_000,
   parameter int TO_BITS     = 26
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       rx_empty_i,
   input  logic [7:0] r_data_i,
   output logic       rd_uart_o,
   input  logic       tx_full_i,
   output logic [7:0] w_data_o,
   output logic       wr_uart_o,
   output logic [7:0] leds_o,
   output logic       op_err_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      GET_A  = 3'd0,
      GET_B  = 3'd1,
      GET_OP = 3'd2,
      EXEC   = 3'd3,
      SEND   = 3'd4
   } state_e;

   localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYC - 1);

   state_e             state_q, state_d;
   logic [7:0]         a_q, a_d, b_q, b_d, op_q, op_d;
   logic [7:0]         res_q, res_d, leds_q, leds_d;
   logic [TO_BITS-1:0] cnt_q, cnt_d;
   logic               rd, wr, err;
   logic [7:0]         alu_res;
   logic               op_known;

   always_comb begin
      alu_res  = 8'h00;
      op_known = 1'b1;
      case (op_q)
         8'h20:   alu_res = a_q + b_q;
         8'h22:   alu_res = a_q - b_q;
         8'h24:   alu_res = a_q & b_q;
         8'h25:   alu_res = a_q | b_q;
         8'h26:   alu_res = a_q ^ b_q;
         8'h27:   alu_res = ~(a_q | b_q);
         8'h02:   alu_res = a_q >> b_q[2:0];
         8'h03:   alu_res = $unsigned($signed(a_q) >>> b_q[2:0]);
         default: op_known = 1'b0;
      endcase
   end

   // Handshake: a byte moves when the FIFO side shows it (rx_empty_i=0 / tx_full_i=0)
   // and this engine pulses rd_uart_o / wr_uart_o in that same cycle.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      leds_d  = leds_q;
      cnt_d   = cnt_q;
      rd      = 1'b0;
      wr      = 1'b0;
      err     = 1'b0;
      case (state_q)
         GET_A: begin
            cnt_d = '0;
            if (!rx_empty_i) begin
               rd      = 1'b1;
               a_d     = r_data_i;
               state_d = GET_B;
            end
         end
         GET_B, GET_OP: begin
            if (!rx_empty_i) begin
               // An arriving byte beats a simultaneous timeout.
               rd    = 1'b1;
               cnt_d = '0;
               if (state_q == GET_B) begin
                  b_d     = r_data_i;
                  state_d = GET_OP;
               end else begin
                  op_d    = r_data_i;
                  state_d = EXEC;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d = GET_A;
               a_d     = 8'h00;
               b_d     = 8'h00;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         EXEC: begin
            cnt_d   = '0;
            res_d   = alu_res;
            err     = !op_known;
            state_d = SEND;
         end
         SEND: begin
            cnt_d = '0;
            if (!tx_full_i) begin
               wr      = 1'b1;
               leds_d  = res_q;
               state_d = GET_A;
            end
         end
         default: state_d = GET_A;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= GET_A;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         op_q    <= 8'h00;
         res_q   <= 8'h00;
         leds_q  <= 8'h00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         leds_q  <= leds_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rd_uart_o = rd  & ~reset_i;
   assign wr_uart_o = wr  & ~reset_i;
   assign op_err_o  = err & ~reset_i;
   assign w_data_o  = res_q;
   assign leds_o    = leds_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed bench for uart_alu_if: a queue models the RX FIFO, written bytes are
// collected and compared against hand-computed results.
module tb_uart_alu_if;

   localparam int TIMEOUT_CYC = 100;
   localparam int TO_BITS     = 8;
   localparam int S_GET_A = 0, S_GET_B = 1, S_GET_OP = 2, S_EXEC = 3, S_SEND = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       tx_full;
   logic       rd_uart, wr_uart, op_err;
   logic [7:0] w_data, leds;
   logic [2:0] state;

   logic [7:0] rx_q[$];
   logic [7:0] got_q[$];
   int         n_checks   = 0;
   int         n_errors   = 0;
   int         op_err_cnt = 0;
   logic       pend_rd = 1'b0, pend_wr = 1'b0;
   logic [7:0] pend_wd = 8'h00;

   uart_alu_if #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_BITS(TO_BITS)) dut (
      .clk_i(clk), .reset_i(reset), .rx_empty_i(rx_empty), .r_data_i(r_data),
      .rd_uart_o(rd_uart), .tx_full_i(tx_full), .w_data_o(w_data),
      .wr_uart_o(wr_uart), .leds_o(leds), .op_err_o(op_err), .state_o(state)
   );

   always #5 clk = ~clk;

   function automatic void refresh_rx();
      rx_empty = (rx_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_q[0];
   endfunction

   always @(negedge clk) begin
      pend_rd = rd_uart;
      pend_wr = wr_uart;
      pend_wd = w_data;
      if (op_err) op_err_cnt++;
   end

   always @(posedge clk) begin
      #1;
      if (pend_rd && rx_q.size() > 0) void'(rx_q.pop_front());
      if (pend_wr) got_q.push_back(pend_wd);
      refresh_rx();
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      @(posedge clk);
      #2;
      rx_q.push_back(a);
      rx_q.push_back(b);
      rx_q.push_back(op);
      refresh_rx();
   endtask

   task automatic wait_state(input string tag, input int st);
      int n = 0;
      @(negedge clk);
      while (int'(state) != st && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, int'(state), st);
   endtask

   task automatic expect_result(input string tag, input logic [7:0] exp);
      int n = 0;
      @(negedge clk);
      while (got_q.size() == 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_wr_cnt"}, got_q.size(), 1);
      if (got_q.size() > 0) begin
         check(tag, got_q.pop_front(), exp);
         check({tag, "_leds"}, leds, exp);
      end
   endtask

   logic [7:0] vec_a[5]   = '{8'h03, 8'hFF, 8'h80, 8'h80, 8'h0F};
   logic [7:0] vec_b[5]   = '{8'h05, 8'h01, 8'h02, 8'h0A, 8'hF0};
   logic [7:0] vec_op[5]  = '{8'h22, 8'h20, 8'h03, 8'h02, 8'h27};
   logic [7:0] vec_exp[5] = '{8'hFE, 8'h00, 8'hE0, 8'h20, 8'h00};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int err_before;
      reset   = 1'b1;
      tx_full = 1'b0;
      refresh_rx();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", int'(state), S_GET_A);
      check("rst_rd", int'(rd_uart), 0);
      check("rst_wr", int'(wr_uart), 0);
      check("rst_err", int'(op_err), 0);
      check("rst_wdata", int'(w_data), 0);
      check("rst_leds", int'(leds), 0);
      @(posedge clk);
      #2 reset = 1'b0;

      // ADD with cycle-accurate timing
      send_frame(8'h05, 8'h03, 8'h20);
      @(negedge clk); check("add_rd0", int'(rd_uart), 1);
      @(negedge clk); check("add_rd1", int'(rd_uart), 1);
      @(negedge clk); check("add_rd2", int'(rd_uart), 1);
      @(negedge clk);
      check("add_exec_state", int'(state), S_EXEC);
      check("add_exec_rd", int'(rd_uart), 0);
      check("add_exec_wr", int'(wr_uart), 0);
      @(negedge clk);
      check("add_wr", int'(wr_uart), 1);
      check("add_rd_in_send", int'(rd_uart), 0);
      check("add_wdata", int'(w_data), 8'h08);
      @(negedge clk);
      check("add_wr_off", int'(wr_uart), 0);
      check("add_leds", int'(leds), 8'h08);
      check("add_state_next", int'(state), S_GET_A);
      check("add_wr_cnt", got_q.size(), 1);
      if (got_q.size() > 0) check("add_got", got_q.pop_front(), 8'h08);

      for (int i = 0; i < 5; i++) begin
         send_frame(vec_a[i], vec_b[i], vec_op[i]);
         expect_result($sformatf("edge%0d", i), vec_exp[i]);
      end

      // Backpressure with a second frame queued behind the first
      @(posedge clk);
      #2 tx_full = 1'b1;
      send_frame(8'h10, 8'h01, 8'h20);
      rx_q.push_back(8'h01);
      rx_q.push_back(8'h01);
      rx_q.push_back(8'h20);
      refresh_rx();
      wait_state("bp_enter", S_SEND);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp_wr%0d", i), int'(wr_uart), 0);
         check($sformatf("bp_rd%0d", i), int'(rd_uart), 0);
         check($sformatf("bp_wdata%0d", i), int'(w_data), 8'h11);
         @(negedge clk);
      end
      check("bp_rx_left", rx_q.size(), 3);
      check("bp_no_write", got_q.size(), 0);
      @(posedge clk);
      #2 tx_full = 1'b0;
      expect_result("bp_first", 8'h11);
      expect_result("bp_second", 8'h02);
      repeat (10) @(negedge clk);
      check("bp_extra_writes", got_q.size(), 0);

      // Timeout discards a two-byte partial frame
      @(posedge clk);
      #2;
      rx_q.push_back(8'h01);
      rx_q.push_back(8'h02);
      refresh_rx();
      wait_state("to_get_op", S_GET_OP);
      repeat (95) @(negedge clk);
      check("to_before_expiry", int'(state), S_GET_OP);
      repeat (10) @(negedge clk);
      check("to_after_expiry", int'(state), S_GET_A);
      check("to_no_write", got_q.size(), 0);
      send_frame(8'h04, 8'h04, 8'h20);
      expect_result("to_realign", 8'h08);

      // Unknown opcode
      err_before = op_err_cnt;
      send_frame(8'h12, 8'h34, 8'h11);
      expect_result("bad_op", 8'h00);
      check("bad_op_err_pulses", op_err_cnt - err_before, 1);
      send_frame(8'h01, 8'h02, 8'h25);
      expect_result("or_op", 8'h03);
      check("or_no_err", op_err_cnt - err_before, 1);

      // Reset mid-frame
      @(posedge clk);
      #2;
      rx_q.push_back(8'h07);
      rx_q.push_back(8'h08);
      refresh_rx();
      wait_state("mid_get_op", S_GET_OP);
      @(posedge clk);
      #2;
      reset = 1'b1;
      rx_q.push_back(8'h09);
      refresh_rx();
      @(negedge clk);
      check("mid_rst_rd", int'(rd_uart), 0);
      check("mid_rst_wr", int'(wr_uart), 0);
      @(negedge clk);
      check("mid_rst_state", int'(state), S_GET_A);
      check("mid_rst_wdata", int'(w_data), 0);
      check("mid_rst_leds", int'(leds), 0);
      check("mid_rst_rd2", int'(rd_uart), 0);
      @(posedge clk);
      #2;
      rx_q.delete();
      refresh_rx();
      reset = 1'b0;
      send_frame(8'h02, 8'h03, 8'h24);
      expect_result("post_rst_and", 8'h02);
      repeat (5) @(negedge clk);
      check("final_no_writes", got_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
